// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: presents tuning words to the DDS core with a
// valid/ack handshake and holds each step for a number of sample strobes.
module dds_sweep_ctrl #(
    parameter int TW_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Fg_CLK,
    input  logic                 Fg_RESET,
    input  logic                 Start,
    input  logic                 Stop,
    input  logic                 SampleEn,
    input  logic [TW_WIDTH-1:0]  CfgStartTW,
    input  logic [TW_WIDTH-1:0]  CfgStepTW,
    input  logic [CNT_WIDTH-1:0] CfgNumSteps,
    input  logic [CNT_WIDTH-1:0] CfgDwell,
    input  logic                 CfgDir,
    input  logic                 CfgLoop,
    input  logic                 TwAck,
    output logic [TW_WIDTH-1:0]  TuningWord,
    output logic                 TwValid,
    output logic                 Busy,
    output logic                 Done,
    output logic [CNT_WIDTH-1:0] StepIdx
);

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_DWELL, S_DONE} state_t;

    state_t state, state_nxt;

    logic [TW_WIDTH-1:0]  start_q, step_q, tw_q;
    logic [CNT_WIDTH-1:0] last_q, dwell_q, cnt_q, idx_q;
    logic                 dir_q, loop_q;
    logic                 accept, ack_hit, strobe, dwell_end, last_step;

    // last_q and dwell_q hold (count - 1) so a zero field behaves like one.
    assign accept    = (state == S_IDLE) && Start && !Stop;
    assign ack_hit   = (state == S_PRESENT) && TwAck && !Stop;
    assign strobe    = (state == S_DWELL) && SampleEn && !Stop;
    assign dwell_end = strobe && (cnt_q == dwell_q);
    assign last_step = (idx_q == last_q);

    always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
        if (Fg_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (Stop) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:    if (Start) state_nxt = S_PRESENT;
                S_PRESENT: if (TwAck) state_nxt = S_DWELL;
                S_DWELL: begin
                    if (dwell_end) begin
                        state_nxt = (last_step && !loop_q) ? S_DONE : S_PRESENT;
                    end
                end
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        TwValid = (state == S_PRESENT);
        Busy    = (state == S_PRESENT) || (state == S_DWELL);
        Done    = (state == S_DONE);
    end

    always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
        if (Fg_RESET) begin
            start_q <= '0;
            step_q  <= '0;
            tw_q    <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            if (accept) begin
                start_q <= CfgStartTW;
                step_q  <= CfgStepTW;
                last_q  <= (CfgNumSteps == '0) ? '0 : CfgNumSteps - 1'b1;
                dwell_q <= (CfgDwell == '0) ? '0 : CfgDwell - 1'b1;
                dir_q   <= CfgDir;
                loop_q  <= CfgLoop;
                tw_q    <= CfgStartTW;
                idx_q   <= '0;
            end
            if (ack_hit) begin
                cnt_q <= '0;
            end
            if (strobe) begin
                if (!dwell_end) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (!last_step) begin
                    idx_q <= idx_q + 1'b1;
                    tw_q  <= dir_q ? tw_q - step_q : tw_q + step_q;
                end else if (loop_q) begin
                    idx_q <= '0;
                    tw_q  <= start_q;
                end
            end
        end
    end

    assign TuningWord = tw_q;
    assign StepIdx    = idx_q;

endmodule
